// File: rtl/hy_frame_sender_if.sv
// Bus bundles for hy_frame_sender.
//   hy_stream_if : upstream word stream (valid/ready handshake, 24 words per frame).
//     master = upstream producer, slave = frame sender.
//   hy_load_if   : detector load port (start pulse, q index, H/Y words, completion).
//     master = frame sender, slave = MIMO detector.

interface hy_stream_if #(
  parameter int N = 32
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_r;
  logic signed [N-1:0] in_i;
  logic                in_last;

  modport master (output in_valid, in_r, in_i, in_last, input in_ready);
  modport slave  (input in_valid, in_r, in_i, in_last, output in_ready);
endinterface

interface hy_load_if #(
  parameter int N = 32
);
  logic                start_new_q;
  logic [3:0]          q_index;
  logic                H_in_valid;
  logic signed [N-1:0] H_in_r;
  logic signed [N-1:0] H_in_i;
  logic                Y_in_valid;
  logic signed [N-1:0] Y_in_r;
  logic signed [N-1:0] Y_in_i;
  logic                det_done;

  modport master (output start_new_q, q_index, H_in_valid, H_in_r, H_in_i,
                         Y_in_valid, Y_in_r, Y_in_i,
                  input  det_done);
  modport slave  (input  start_new_q, q_index, H_in_valid, H_in_r, H_in_i,
                         Y_in_valid, Y_in_r, Y_in_i,
                  output det_done);
endinterface

// File: rtl/hy_frame_sender.sv
// hy_frame_sender: buffers up to two 24-word frames (16 H words, 8 Y words) in
// ping-pong banks and replays each one to the MIMO detector in its load timing:
// start pulse at T, H[0..15] over T+1..T+16, Y[0..7] alongside H[0..7], then
// waits for det_done (or a TIMEOUT_CYC-cycle timeout) before freeing the bank.
// Optional feature macro: HY_SENDER_STATS_EN adds frames_sent / stall_cycles
// saturating counters; without it those ports and counters do not exist.

module hy_frame_sender #(
  parameter int N           = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rstn,
  hy_stream_if.slave  up,
  hy_load_if.master   det,
  output logic        frame_err,
  output logic        timeout
`ifdef HY_SENDER_STATS_EN
  ,
  output logic [15:0] frames_sent,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_WAIT} state_t;

  localparam int            WW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);

  // Bank b of H occupies h_mem[b*16 +: 16]; bank b of Y occupies y_mem[b*8 +: 8].
  // Separate arrays let one H word and one Y word be read in the same cycle.
  logic [2*N-1:0] h_mem [0:31];
  logic [2*N-1:0] y_mem [0:15];

  // Write side
  logic [1:0] full_reg;
  logic [1:0] full_next;
  logic       fill_bank_reg;
  logic       fill_bank_next;
  logic [4:0] wcnt_reg;
  logic [4:0] wcnt_next;
  logic       frame_err_next;
  logic       wr_acc;
  logic       wr_bad;

  // Read side
  state_t        state_reg;
  logic          send_bank_reg;
  logic [4:0]    scnt_reg;
  logic [WW-1:0] wait_cnt_reg;
  logic          release_now;

  assign wr_acc = up.in_valid && up.in_ready;
  // A frame is well formed only if in_last coincides exactly with word 23.
  assign wr_bad = wr_acc && (up.in_last != (wcnt_reg == 5'd23));

  // The bank is freed on det_done or on the last allowed wait cycle.
  assign release_now = (state_reg == S_WAIT) &&
                       (det.det_done || (wait_cnt_reg == WAIT_LAST));

  // Next bank occupancy: release is applied before a fill completion so both
  // take effect when they land in the same cycle.
  always_comb begin
    full_next      = full_reg;
    fill_bank_next = fill_bank_reg;
    wcnt_next      = wcnt_reg;
    frame_err_next = 1'b0;
    if (release_now) begin
      full_next[send_bank_reg] = 1'b0;
    end
    if (wr_acc) begin
      if (wr_bad) begin
        frame_err_next = 1'b1;
        wcnt_next      = 5'd0;
      end else if (wcnt_reg == 5'd23) begin
        full_next[fill_bank_reg] = 1'b1;
        fill_bank_next           = ~fill_bank_reg;
        wcnt_next                = 5'd0;
      end else begin
        wcnt_next = wcnt_reg + 5'd1;
      end
    end
  end

  // Write-side state; in_ready is registered from next-state so it never
  // depends combinationally on in_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_reg      <= 2'b00;
      fill_bank_reg <= 1'b0;
      wcnt_reg      <= 5'd0;
      up.in_ready   <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      full_reg      <= full_next;
      fill_bank_reg <= fill_bank_next;
      wcnt_reg      <= wcnt_next;
      up.in_ready   <= ~full_next[fill_bank_next];
      frame_err     <= frame_err_next;
    end
  end

  // Frame storage; words of a later-rejected frame are simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (wcnt_reg < 5'd16) begin
        h_mem[{fill_bank_reg, wcnt_reg[3:0]}] <= {up.in_r, up.in_i};
      end else begin
        y_mem[{fill_bank_reg, wcnt_reg[2:0]}] <= {up.in_r, up.in_i};
      end
    end
  end

  // Replay FSM with registered load outputs; data is forced to 0 when not valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= S_IDLE;
      send_bank_reg   <= 1'b0;
      scnt_reg        <= 5'd0;
      wait_cnt_reg    <= '0;
      timeout         <= 1'b0;
      det.start_new_q <= 1'b0;
      det.q_index     <= 4'd0;
      det.H_in_valid  <= 1'b0;
      det.H_in_r      <= '0;
      det.H_in_i      <= '0;
      det.Y_in_valid  <= 1'b0;
      det.Y_in_r      <= '0;
      det.Y_in_i      <= '0;
    end else begin
      det.start_new_q <= 1'b0;
      det.H_in_valid  <= 1'b0;
      det.H_in_r      <= '0;
      det.H_in_i      <= '0;
      det.Y_in_valid  <= 1'b0;
      det.Y_in_r      <= '0;
      det.Y_in_i      <= '0;
      case (state_reg)
        S_IDLE: begin
          if (full_reg[send_bank_reg]) begin
            det.start_new_q <= 1'b1;
            state_reg       <= S_START;
          end
        end
        S_START: begin
          det.H_in_valid             <= 1'b1;
          {det.H_in_r, det.H_in_i}   <= h_mem[{send_bank_reg, 4'd0}];
          det.Y_in_valid             <= 1'b1;
          {det.Y_in_r, det.Y_in_i}   <= y_mem[{send_bank_reg, 3'd0}];
          scnt_reg                   <= 5'd1;
          state_reg                  <= S_SEND;
        end
        S_SEND: begin
          if (scnt_reg == 5'd16) begin
            wait_cnt_reg <= '0;
            state_reg    <= S_WAIT;
          end else begin
            det.H_in_valid           <= 1'b1;
            {det.H_in_r, det.H_in_i} <= h_mem[{send_bank_reg, scnt_reg[3:0]}];
            if (scnt_reg < 5'd8) begin
              det.Y_in_valid           <= 1'b1;
              {det.Y_in_r, det.Y_in_i} <= y_mem[{send_bank_reg, scnt_reg[2:0]}];
            end
            scnt_reg <= scnt_reg + 5'd1;
          end
        end
        S_WAIT: begin
          if (release_now) begin
            if (!det.det_done) begin
              timeout <= 1'b1;
            end
            send_bank_reg <= ~send_bank_reg;
            det.q_index   <= det.q_index + 4'd1;
            state_reg     <= S_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef HY_SENDER_STATS_EN
  // Saturating counters of released frames and upstream stall cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frames_sent  <= 16'd0;
      stall_cycles <= 16'd0;
    end else begin
      if (release_now && (frames_sent != 16'hFFFF)) begin
        frames_sent <= frames_sent + 16'd1;
      end
      if (up.in_valid && !up.in_ready && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hy_frame_sender.sv
// Self-checking bench for hy_frame_sender: table of frame vectors plus
// hand-written sequences (back-to-back blocking, timeout, reset mid-send,
// q_index wrap). Expected H/Y words and q indices are queued when a frame is
// pushed and popped when the detector port presents them.

module tb_hy_frame_sender;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  hy_stream_if #(.N(N)) s_if ();
  hy_load_if   #(.N(N)) l_if ();
  logic frame_err;
  logic timeout;
`ifdef HY_SENDER_STATS_EN
  logic [15:0] frames_sent;
  logic [15:0] stall_cycles;
`endif

  hy_frame_sender #(.N(N), .TIMEOUT_CYC(256)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .up          (s_if),
    .det         (l_if),
    .frame_err   (frame_err),
    .timeout     (timeout)
`ifdef HY_SENDER_STATS_EN
    ,
    .frames_sent (frames_sent),
    .stall_cycles(stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_h [$];
  logic [63:0] exp_y [$];
  logic [3:0]  exp_q [$];
  int          lat_q [$];
  int q_model = 0;

  int phase = 0;
  int done_timer = -1;
  int n_starts = 0;
  int n_done = 0;
  int n_ferr = 0;
  int cyc = 0;
  int last_h_cyc = 0;
  int timeout_cyc = 0;
  bit timeout_seen = 0;
  int manual_req_cnt = 0;
  int manual_seen = 0;

  typedef struct {
    int hb;
    int yb;
    int bad_pos;   // -1 good frame, 0..22 in_last early, 23 word 23 without in_last
    int lat;       // det_done delay after last H, -1 = withheld
    int exp_err;
    int exp_start;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor + detector responder: one process so det_done timing is deterministic.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      phase        = 0;
      done_timer   = -1;
      manual_seen  = manual_req_cnt;
      timeout_seen = 0;
      l_if.det_done = 1'b0;
    end else begin
      l_if.det_done = 1'b0;
      if (manual_seen != manual_req_cnt) begin
        manual_seen   = manual_req_cnt;
        l_if.det_done = 1'b1;
        n_done++;
      end else if (done_timer == 0) begin
        l_if.det_done = 1'b1;
        done_timer    = -1;
        n_done++;
      end else if (done_timer > 0) begin
        done_timer--;
      end
      if (frame_err) n_ferr++;
      if (timeout && !timeout_seen) begin
        timeout_seen = 1;
        timeout_cyc  = cyc;
      end
      if (phase == 0) begin
        if (l_if.start_new_q) begin
          n_starts++;
          check("start_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("q_index", l_if.q_index, exp_q.pop_front());
          phase = 1;
        end
      end else if (phase <= 16) begin
        check("start_width", l_if.start_new_q, 0);
        check("h_valid", l_if.H_in_valid, 1);
        check("h_avail", 64'(exp_h.size() != 0), 1);
        if (exp_h.size() != 0) check("h_data", {l_if.H_in_r, l_if.H_in_i}, exp_h.pop_front());
        check("y_valid", l_if.Y_in_valid, 64'(phase <= 8));
        if (phase <= 8) begin
          check("y_avail", 64'(exp_y.size() != 0), 1);
          if (exp_y.size() != 0) check("y_data", {l_if.Y_in_r, l_if.Y_in_i}, exp_y.pop_front());
        end else begin
          check("y_zero", {l_if.Y_in_r, l_if.Y_in_i}, 0);
        end
        if (phase == 16) begin
          last_h_cyc = cyc;
          done_timer = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
        end
        phase++;
      end else begin
        check("h_valid_end", l_if.H_in_valid, 0);
        check("h_zero_end", {l_if.H_in_r, l_if.H_in_i}, 0);
        check("y_valid_end", l_if.Y_in_valid, 0);
        phase = 0;
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
    s_if.in_r     = '0;
    s_if.in_i     = '0;
  endtask

  task automatic push_word(input int r, input int i, input bit last);
    int g = 0;
    @(negedge clk);
    s_if.in_valid = 1'b1;
    s_if.in_r     = r;
    s_if.in_i     = i;
    s_if.in_last  = last;
    while (!s_if.in_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) check("in_ready_wait", s_if.in_ready, 1);
  endtask

  task automatic push_frame(input int hb, input int yb, input int bad_pos, input int lat);
    int nwords;
    int val;
    bit last;
    if (bad_pos < 0) begin
      for (int k = 0; k < 16; k++) exp_h.push_back({32'(hb + k), 32'(-(hb + k))});
      for (int j = 0; j < 8; j++)  exp_y.push_back({32'(yb + j), 32'(-(yb + j))});
      exp_q.push_back(4'(q_model));
      q_model = (q_model + 1) % 16;
      lat_q.push_back(lat);
    end
    nwords = (bad_pos >= 0 && bad_pos < 23) ? bad_pos + 1 : 24;
    for (int k = 0; k < nwords; k++) begin
      val  = (k < 16) ? hb + k : yb + k - 16;
      last = (bad_pos < 0) ? (k == 23) : ((bad_pos < 23) ? (k == bad_pos) : 1'b0);
      push_word(val, -val, last);
    end
    idle();
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int g = 0;
    while (n_done < target && g < budget) begin
      @(negedge clk);
      g++;
    end
    check(name, 64'(n_done >= target), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, f0, g;
    vecs[0] = '{1,   100, -1, 5, 0, 1};
    vecs[1] = '{200, 300, -1, 1, 0, 1};
    vecs[2] = '{7,   8,   10, 0, 1, 0};
    vecs[3] = '{-50, -60, -1, 0, 0, 1};
    vecs[4] = '{9,   9,   23, 0, 1, 0};

    rstn = 1'b0;
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
    s_if.in_r     = '0;
    s_if.in_i     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", s_if.in_ready, 0);
    check("rst_start", l_if.start_new_q, 0);
    check("rst_h_valid", l_if.H_in_valid, 0);
    check("rst_y_valid", l_if.Y_in_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_q_index", l_if.q_index, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", s_if.in_ready, 1);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      s0 = n_starts; f0 = n_ferr; d0 = n_done;
      push_frame(vecs[v].hb, vecs[v].yb, vecs[v].bad_pos, vecs[v].lat);
      if (vecs[v].exp_start != 0) wait_done(d0 + 1, 200, "vec_done");
      else repeat (30) @(negedge clk);
      check("vec_frame_err", 64'(n_ferr - f0), 64'(vecs[v].exp_err));
      check("vec_starts", 64'(n_starts - s0), 64'(vecs[v].exp_start));
      $display("vec %0d: hb=%0d bad_pos=%0d starts=%0d ferr=%0d", v, vecs[v].hb,
               vecs[v].bad_pos, n_starts - s0, n_ferr - f0);
    end

    // Three frames back-to-back, first det_done withheld
    s0 = n_starts; d0 = n_done;
    push_frame(1000, 2000, -1, -1);
    push_frame(3000, 4000, -1, 2);
    check("in_ready_both_full", s_if.in_ready, 0);
    fork
      push_frame(5000, 6000, -1, 2);
    join_none
    repeat (30) @(negedge clk);
    check("only_first_started", 64'(n_starts - s0), 1);
    manual_req_cnt++;
    wait_done(d0 + 3, 400, "three_done");
    wait fork;
    check("three_started", 64'(n_starts - s0), 3);

    // Timeout: no det_done at all
    d0 = n_done;
    push_frame(11, 22, -1, -1);
    g = 0;
    while (!timeout_seen && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("timeout_set", timeout, 1);
    check("timeout_delay", 64'(timeout_cyc - last_h_cyc), 257);
    push_frame(33, 44, -1, 2);
    wait_done(d0 + 1, 200, "after_timeout_done");
    check("timeout_sticky", timeout, 1);

    // Reset during T+5 of a send
    s0 = n_starts;
    push_frame(55, 66, -1, 3);
    g = 0;
    while (n_starts == s0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_h_valid", l_if.H_in_valid, 0);
    check("rst_mid_y_valid", l_if.Y_in_valid, 0);
    check("rst_mid_h_zero", {l_if.H_in_r, l_if.H_in_i}, 0);
    exp_h.delete(); exp_y.delete(); exp_q.delete(); lat_q.delete();
    q_model = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    s0 = n_starts;
    repeat (40) @(negedge clk);
    check("no_start_after_rst", 64'(n_starts - s0), 0);
    check("timeout_cleared", timeout, 0);
    check("q_index_cleared", l_if.q_index, 0);
    check("in_ready_after_mid_rst", s_if.in_ready, 1);

    // 17 frames: q_index 0..15 then 0
    d0 = n_done;
    for (int f = 0; f < 17; f++) begin
      push_frame(f * 10 + 1, f * 10 + 500, -1, 1);
      $display("frame %0d pushed, q expected %0d", f, f % 16);
    end
    wait_done(d0 + 17, 3000, "seventeen_done");
    check("q_index_wrap", l_if.q_index, 64'(q_model));
`ifdef HY_SENDER_STATS_EN
    check("frames_sent", frames_sent, 17);
`endif

    check("h_queue_empty", 64'(exp_h.size()), 0);
    check("y_queue_empty", 64'(exp_y.size()), 0);
    check("q_queue_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
